// File: rtl/serial_add_sub.sv
`default_nettype none
// ============================================================================
// Module      : serial_add_sub
// Description : Bit-serial two's complement adder/subtractor. The operation
//               runs LSB first through one full-adder cell with a registered
//               carry, one bit per clock. The result, carry-out and signed
//               overflow are presented together with a one-cycle done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_add_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow
);

  localparam int             CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q;
  // a_q doubles as the partial-sum shift register: operand bits leave at the
  // LSB while sum bits enter at the MSB, so after WIDTH shifts it holds the sum.
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic               carry_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               busy_q;
  logic               done_q;
  logic [WIDTH-1:0]   result_q;
  logic               cout_q;
  logic               ovf_q;

  // Single full-adder cell working on the current LSBs.
  logic               fa_sum;
  logic               fa_carry;
  logic [WIDTH-1:0]   a_d;

  assign fa_sum   = a_q[0] ^ b_q[0] ^ carry_q;
  assign fa_carry = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
  assign a_d      = {fa_sum, a_q[WIDTH-1:1]};

  // Control FSM and datapath; all outputs are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (start) begin
            // Subtraction is A + ~B + 1: invert B and seed the carry with 1.
            a_q     <= a;
            b_q     <= sub ? ~b : b;
            carry_q <= sub;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end else begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        RUN: begin
          a_q     <= a_d;
          b_q     <= {1'b0, b_q[WIDTH-1:1]};
          carry_q <= fa_carry;
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == LAST_BIT) begin
            // MSB cycle: carry_q is the carry into the MSB, fa_carry the one out.
            result_q <= a_d;
            cout_q   <= fa_carry;
            ovf_q    <= carry_q ^ fa_carry;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= DONE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_add_sub.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_add_sub
// Description : Self-checking bench for serial_add_sub (WIDTH=8 and WIDTH=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_add_sub;

  typedef struct packed {
    logic [7:0] res;
    logic       co;
    logic       ov;
  } exp8_t;

  typedef struct packed {
    logic [1:0] res;
    logic       co;
    logic       ov;
  } exp2_t;

  typedef struct {
    logic       sub;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic       co;
    logic       ov;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  logic       start8 = 1'b0, sub8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, cout8, ovf8;
  logic [7:0] result8;

  logic       start2 = 1'b0, sub2 = 1'b0;
  logic [1:0] a2 = '0, b2 = '0;
  logic       busy2, done2, cout2, ovf2;
  logic [1:0] result2;

  int checks = 0;
  int errors = 0;
  int done_cnt8 = 0;
  int done_cnt2 = 0;
  logic prev_done8 = 1'b0;
  logic prev_done2 = 1'b0;

  exp8_t q8[$];
  exp2_t q2[$];
  exp8_t last8 = '0;

  serial_add_sub #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .sub(sub8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .result(result8), .cout(cout8), .overflow(ovf8)
  );

  serial_add_sub #(.WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .sub(sub2), .a(a2), .b(b2),
    .busy(busy2), .done(done2), .result(result2), .cout(cout2), .overflow(ovf2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain wide arithmetic, overflow from operand/result sign bits.
  function automatic logic [33:0] model(input int w, input logic s,
                                        input logic [31:0] x, input logic [31:0] y);
    longint unsigned mask, xx, yy, full;
    logic [31:0] r;
    logic co, ov;
    mask = (64'd1 << w) - 64'd1;
    xx   = {32'b0, x} & mask;
    yy   = s ? (~{32'b0, y}) & mask : {32'b0, y} & mask;
    full = xx + yy + 64'(s);
    r    = 32'(full & mask);
    co   = full[w];
    ov   = (xx[w-1] == yy[w-1]) && (r[w-1] != xx[w-1]);
    return {ov, co, r};
  endfunction

  function automatic exp8_t model8(input logic s, input logic [7:0] x, input logic [7:0] y);
    logic [33:0] m;
    m = model(8, s, {24'b0, x}, {24'b0, y});
    return {m[7:0], m[32], m[33]};
  endfunction

  // Scoreboard for the 8-bit instance: compare every done against the queue.
  always @(negedge clk) begin
    if (done8) begin
      exp8_t e;
      done_cnt8++;
      chk("done8_single_cycle", {31'b0, prev_done8}, 32'd0);
      if (q8.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL done8_unexpected: got done=1, required no done (nothing pending)");
      end else begin
        e = q8.pop_front();
        chk("result8_cout_ovf", {22'b0, result8, cout8, ovf8}, {22'b0, e});
        last8 = e;
      end
    end
    prev_done8 = done8;
  end

  // Scoreboard for the 2-bit instance.
  always @(negedge clk) begin
    if (done2) begin
      exp2_t e;
      done_cnt2++;
      if (q2.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL done2_unexpected: got done=1, required no done (nothing pending)");
      end else begin
        e = q2.pop_front();
        chk("result2_cout_ovf", {28'b0, result2, cout2, ovf2}, {28'b0, e});
      end
    end
    prev_done2 = done2;
  end

  // Called #1 after an accepting edge: follows the run to its done pulse,
  // checking busy stays high and the outputs hold the previous completion.
  task automatic wait_done8(output int n);
    logic ok;
    ok = 1'b1;
    n  = 0;
    while (done8 !== 1'b1 && n < 20) begin
      if (busy8 !== 1'b1 || {result8, cout8, ovf8} !== last8) ok = 1'b0;
      @(posedge clk);
      #1;
      n++;
    end
    chk("run_busy_and_hold", {31'b0, ok}, 32'd1);
    chk("latency8", n, 8);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got simulation still running, required finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[10];
    int   n;
    int   d0;

    vecs[0] = '{1'b0, 8'h05, 8'h03, 8'h08, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 8'h03, 8'h05, 8'hFE, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1};
    vecs[5] = '{1'b0, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1};
    vecs[6] = '{1'b1, 8'h05, 8'h05, 8'h00, 1'b1, 1'b0};
    vecs[7] = '{1'b0, 8'hA5, 8'h5A, 8'hFF, 1'b0, 1'b0};
    vecs[8] = '{1'b1, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b0};
    vecs[9] = '{1'b1, 8'h7F, 8'hFF, 8'h80, 1'b0, 1'b1};

    // Asynchronous reset, checked before any clock edge.
    #3 rst_n = 1'b0;
    #1;
    chk("reset_outputs8", {20'b0, busy8, done8, result8, cout8, ovf8}, 32'd0);
    chk("reset_outputs2", {26'b0, busy2, done2, result2, cout2, ovf2}, 32'd0);

    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven operations; some back-to-back from DONE, some from IDLE.
    for (int i = 0; i < 10; i++) begin
      if (i % 3 == 0) begin
        @(negedge clk);
        @(negedge clk);
      end
      start8 = 1'b1;
      sub8   = vecs[i].sub;
      a8     = vecs[i].a;
      b8     = vecs[i].b;
      q8.push_back({vecs[i].res, vecs[i].co, vecs[i].ov});
      @(posedge clk);
      #1;
      start8 = 1'b0;
      sub8   = 1'($urandom);
      a8     = 8'($urandom);
      b8     = 8'($urandom);
      wait_done8(n);
    end

    // A second start during RUN must be ignored.
    @(negedge clk);
    @(negedge clk);
    start8 = 1'b1; sub8 = 1'b0; a8 = 8'h11; b8 = 8'h22;
    q8.push_back(model8(1'b0, 8'h11, 8'h22));
    @(posedge clk);
    #1;
    start8 = 1'b0;
    d0 = done_cnt8;
    n  = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      n++;
    end
    start8 = 1'b1; sub8 = 1'b1; a8 = 8'hFF; b8 = 8'h0F;
    @(posedge clk);
    #1;
    n++;
    start8 = 1'b0;
    while (done8 !== 1'b1 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("midrun_start_latency", n, 8);
    repeat (12) @(posedge clk);
    #1;
    chk("midrun_start_one_done", done_cnt8 - d0, 1);
    chk("midrun_start_not_relaunched", {31'b0, busy8}, 32'd0);

    // start held through DONE: second operation follows with no idle cycle.
    @(negedge clk);
    start8 = 1'b1; sub8 = 1'b0; a8 = 8'h40; b8 = 8'h41;
    q8.push_back(model8(1'b0, 8'h40, 8'h41));
    @(posedge clk);
    #1;
    sub8 = 1'b1; a8 = 8'h10; b8 = 8'h20;
    q8.push_back(model8(1'b1, 8'h10, 8'h20));
    wait_done8(n);
    @(posedge clk);
    #1;
    start8 = 1'b0;
    wait_done8(n);

    // Reset in the middle of RUN aborts the operation.
    @(negedge clk);
    start8 = 1'b1; sub8 = 1'b0; a8 = 8'h12; b8 = 8'h34;
    q8.push_back(model8(1'b0, 8'h12, 8'h34));
    @(posedge clk);
    #1;
    start8 = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'b0, busy8}, 32'd0);
    chk("abort_done", {31'b0, done8}, 32'd0);
    chk("abort_result_flags", {22'b0, result8, cout8, ovf8}, 32'd0);
    q8.delete();
    last8 = '0;
    d0 = done_cnt8;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    chk("abort_no_done", done_cnt8 - d0, 0);

    // First rising edge after reset release with start=1 is accepted.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n  = 1'b1;
    start8 = 1'b1; sub8 = 1'b1; a8 = 8'h9C; b8 = 8'h3B;
    q8.push_back(model8(1'b1, 8'h9C, 8'h3B));
    @(posedge clk);
    #1;
    start8 = 1'b0;
    wait_done8(n);

    // WIDTH=2 exhaustive add/sub against the reference model.
    for (int s = 0; s < 2; s++) begin
      for (int x = 0; x < 4; x++) begin
        for (int y = 0; y < 4; y++) begin
          logic [33:0] m;
          m = model(2, 1'(s), 32'(x), 32'(y));
          start2 = 1'b1;
          sub2   = 1'(s);
          a2     = 2'(x);
          b2     = 2'(y);
          q2.push_back({m[1:0], m[32], m[33]});
          @(posedge clk);
          #1;
          start2 = 1'b0;
          n = 0;
          while (done2 !== 1'b1 && n < 10) begin
            @(posedge clk);
            #1;
            n++;
          end
          chk("latency2", n, 2);
        end
      end
    end

    repeat (4) @(posedge clk);
    #1;
    chk("queue8_drained", q8.size(), 0);
    chk("queue2_drained", q2.size(), 0);
    chk("done2_count", done_cnt2, 32);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
